// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Contents:
//   W, OPW   - operand/result width and opcode width
//   state_t  - scheduler FSM state encoding
//   cmd_t    - one ALU command (operands, carry-in, opaque opcode)
package alu_sched_pkg;

  localparam int W   = 16;
  localparam int OPW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic [OPW-1:0] opc;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req_valid  in  2  request vector, bit i = requester i
//   last_grant in  1  requester granted on the previous accepted transfer
//   grant      out 2  one-hot grant, or zero when nothing is requested
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A lone request always wins; under contention the requester that did
  // not win last time gets the grant.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req_valid[0] & (~req_valid[1] | last_grant);
    grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant);
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid / req_ready    per-requester command handshake (ready one-hot or zero)
//   req{0,1}_a/_b/_cin/_opc  command fields per requester
//   alu_a/_b/_cin/_opc       registered ALU operand drive
//   alu_w/_zero/_neg         ALU result and flags
//   rsp_valid / rsp_ready    response handshake
//   rsp_id/_w/_zero/_neg     captured response and its owner
//   busy                     high whenever an operation is in flight
//
// state | meaning
// IDLE  | waiting for a command; grants one requester combinationally
// EXEC  | ALU inputs held, counting settle cycles
// RESP  | response presented until rsp_ready
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int EXEC_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req0_cin,
  input  logic [OPW-1:0] req0_opc,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic           req1_cin,
  input  logic [OPW-1:0] req1_opc,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_cin,
  output logic [OPW-1:0] alu_opc,
  input  logic [W-1:0]   alu_w,
  input  logic           alu_zero,
  input  logic           alu_neg,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_w,
  output logic           rsp_zero,
  output logic           rsp_neg,
  output logic           busy
);

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t       state;
  cmd_t         cmd_q;
  cmd_t         cmd_sel;
  logic [3:0]   exec_cnt;
  logic         last_grant;
  logic         owner;
  logic [1:0]   grant;
  logic         accept;
  logic [W-1:0] rsp_w_q;
  logic         rsp_zero_q;
  logic         rsp_neg_q;

  rr_arb2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is gated by rst so no requester sees a handshake during reset.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst) begin
      req_ready = grant;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    cmd_sel = req_ready[1] ? cmd_t'{req1_a, req1_b, req1_cin, req1_opc}
                           : cmd_t'{req0_a, req0_b, req0_cin, req0_opc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      exec_cnt   <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rsp_w_q    <= '0;
      rsp_zero_q <= 1'b0;
      rsp_neg_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q      <= cmd_sel;
            owner      <= req_ready[1];
            last_grant <= req_ready[1];
            exec_cnt   <= 4'd0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          exec_cnt <= exec_cnt + 4'd1;
          if (exec_cnt == EXEC_LAST) begin
            rsp_w_q    <= alu_w;
            rsp_zero_q <= alu_zero;
            rsp_neg_q  <= alu_neg;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive keeps the last command after completion.
  assign alu_a     = cmd_q.a;
  assign alu_b     = cmd_q.b;
  assign alu_cin   = cmd_q.cin;
  assign alu_opc   = cmd_q.opc;

  assign rsp_valid = (state == RESP);
  assign rsp_id    = owner;
  assign rsp_w     = rsp_w_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_neg   = rsp_neg_q;
  assign busy      = (state != IDLE);

endmodule
